// File: rtl/piso_serializer_pkg.sv
// rtl/piso_serializer_pkg.sv - shared FSM state type and counter sizing for the serializer
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // A 2-bit word still needs one counter bit, so never drop to zero width.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// rtl/piso_serializer_if.sv - load handshake and serial output bundle
interface piso_serializer_if #(
  parameter int WIDTH = 8
) ();

  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             shift_en;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_last;
  logic             busy;

  modport master (
    output load_valid, load_data, shift_en,
    input  load_ready, ser_out, ser_valid, ser_last, busy
  );

  modport slave (
    input  load_valid, load_data, shift_en,
    output load_ready, ser_out, ser_valid, ser_last, busy
  );

endinterface

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parametrised parallel-in/serial-out shifter with valid/ready load
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input logic               clk,
  input logic               reset,
  piso_serializer_if.slave  bus
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    cnt;
  logic             in_shift;
  logic             at_last;
  logic             accept;

  assign in_shift = (state == SHIFT);
  assign at_last  = in_shift && (cnt == '0);

  // The last-bit strobe frees the register, which is what allows zero-gap reloads.
  assign bus.load_ready = !reset && (!in_shift || (at_last && bus.shift_en));
  assign accept         = bus.load_valid && bus.load_ready;

  always_comb begin
    shifted = shift_reg;
    if (MSB_FIRST)
      shifted = {shift_reg[WIDTH-2:0], IDLE_LEVEL};
    else
      shifted = {IDLE_LEVEL, shift_reg[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= {WIDTH{IDLE_LEVEL}};
      cnt       <= '0;
    end else if (accept) begin
      state     <= SHIFT;
      shift_reg <= bus.load_data;
      cnt       <= CNT_LOAD;
    end else if (in_shift && bus.shift_en) begin
      if (cnt == '0) begin
        state     <= IDLE;
        shift_reg <= {WIDTH{IDLE_LEVEL}};
      end else begin
        shift_reg <= shifted;
        cnt       <= cnt - CW'(1);
      end
    end
  end

  assign bus.ser_out   = in_shift ? (MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0]) : IDLE_LEVEL;
  assign bus.ser_valid = in_shift;
  assign bus.busy      = in_shift;
  assign bus.ser_last  = at_last;

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - table-driven scoreboard bench for MSB- and LSB-first serializers
module tb_piso_serializer;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic [7:0] seq;
    int         period;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       shift_en;
  logic       lv [2];
  logic [7:0] ld [2];
  int         period;
  int         cyc;
  int         n_cmp;
  int         n_bad;
  int         vcnt [2];
  int         first_c [2];
  int         last_c [2];
  exp_t       q0 [$];
  exp_t       q1 [$];
  vec_t       vecs [6];

  piso_serializer_if #(.WIDTH(8)) if_m ();
  piso_serializer_if #(.WIDTH(8)) if_l ();

  assign if_m.load_valid = lv[0];
  assign if_m.load_data  = ld[0];
  assign if_m.shift_en   = shift_en;
  assign if_l.load_valid = lv[1];
  assign if_l.load_data  = ld[1];
  assign if_l.shift_en   = shift_en;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
    .clk(clk), .reset(reset), .bus(if_m)
  );
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_l (
    .clk(clk), .reset(reset), .bus(if_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe generator: shift_en is high on every cycle whose count is a multiple of period.
  initial begin
    cyc = 0;
    shift_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      shift_en = ((cyc % period) == 0);
    end
  end

  function automatic logic rdy(input int s);
    return (s == 0) ? if_m.load_ready : if_l.load_ready;
  endfunction
  function automatic logic sv(input int s);
    return (s == 0) ? if_m.ser_valid : if_l.ser_valid;
  endfunction
  function automatic logic sl(input int s);
    return (s == 0) ? if_m.ser_last : if_l.ser_last;
  endfunction
  function automatic logic so(input int s);
    return (s == 0) ? if_m.ser_out : if_l.ser_out;
  endfunction
  function automatic logic sb(input int s);
    return (s == 0) ? if_m.busy : if_l.busy;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  task automatic push(input int s, input logic [7:0] seq);
    exp_t e;
    for (int i = 7; i >= 0; i--) begin
      e.b    = seq[i];
      e.last = (i == 0);
      if (s == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic mon(input int s);
    exp_t e;
    int   qs;
    if (sv(s)) begin
      vcnt[s]++;
      if (first_c[s] < 0) first_c[s] = cyc;
      last_c[s] = cyc;
      qs = (s == 0) ? q0.size() : q1.size();
      if (qs == 0) begin
        chk($sformatf("unexpected_bit_dut%0d", s), 1, 0);
      end else begin
        e = (s == 0) ? q0[0] : q1[0];
        chk($sformatf("ser_out_dut%0d", s), int'(so(s)), int'(e.b));
        chk($sformatf("ser_last_dut%0d", s), int'(sl(s)), int'(e.last));
        chk($sformatf("busy_dut%0d", s), int'(sb(s)), 1);
        if (shift_en) begin
          if (s == 0) void'(q0.pop_front());
          else        void'(q1.pop_front());
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      mon(0);
      mon(1);
    end
  end

  // Offer a word aligned to a strobe, wait for the handshake, and queue its expected bits.
  task automatic send(input int s, input logic [7:0] d, input logic [7:0] seq);
    int n;
    bit ok;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (shift_en) break;
      n++;
    end
    ld[s] = d;
    lv[s] = 1'b1;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 500) begin
      if (rdy(s)) begin
        ok = 1'b1;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    if (ok) begin
      if (sv(s)) chk("ready_only_at_last_strobe", int'(sl(s) && shift_en), 1);
      push(s, seq);
      @(posedge clk);
      #1;
      lv[s] = 1'b0;
      ld[s] = ~d;
    end else begin
      chk("accept_timeout", 0, 1);
      lv[s] = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (n < 2000 && (q0.size() != 0 || q1.size() != 0 || sv(0) || sv(1))) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("drain_timeout", 0, 1);
  endtask

  task automatic check_idle(input int s, input int ready_req);
    chk($sformatf("idle_ser_out_dut%0d", s), int'(so(s)), 0);
    chk($sformatf("idle_ser_valid_dut%0d", s), int'(sv(s)), 0);
    chk($sformatf("idle_ser_last_dut%0d", s), int'(sl(s)), 0);
    chk($sformatf("idle_busy_dut%0d", s), int'(sb(s)), 0);
    chk($sformatf("idle_load_ready_dut%0d", s), int'(rdy(s)), ready_req);
  endtask

  task automatic clear_stats();
    for (int s = 0; s < 2; s++) begin
      vcnt[s]    = 0;
      first_c[s] = -1;
      last_c[s]  = -1;
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    period = 1;
    reset  = 1'b1;
    lv[0] = 1'b0; lv[1] = 1'b0;
    ld[0] = 8'h00; ld[1] = 8'h00;
    clear_stats();

    vecs[0] = '{sel: 0, data: 8'hC1, seq: 8'b11000001, period: 1};
    vecs[1] = '{sel: 1, data: 8'hC1, seq: 8'b10000011, period: 1};
    vecs[2] = '{sel: 0, data: 8'h3C, seq: 8'b00111100, period: 2};
    vecs[3] = '{sel: 1, data: 8'h01, seq: 8'b10000000, period: 1};
    vecs[4] = '{sel: 1, data: 8'h96, seq: 8'b01101001, period: 3};
    vecs[5] = '{sel: 0, data: 8'hC1, seq: 8'b11000001, period: 4};

    #12;
    check_idle(0, 0);
    check_idle(1, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_idle(0, 1);
    check_idle(1, 1);

    for (int i = 0; i < 6; i++) begin
      period = vecs[i].period;
      clear_stats();
      send(vecs[i].sel, vecs[i].data, vecs[i].seq);
      drain();
      chk($sformatf("valid_cycles_vec%0d", i), vcnt[vecs[i].sel], 8 * vecs[i].period);
      check_idle(vecs[i].sel, 1);
    end

    // Word offered mid-stream must wait for the final strobe of the current word.
    period = 4;
    clear_stats();
    send(0, 8'hC1, 8'b11000001);
    repeat (10) @(posedge clk);
    send(0, 8'hFF, 8'hFF);
    drain();
    chk("midword_valid_cycles", vcnt[0], 64);
    chk("midword_no_gap", last_c[0] - first_c[0] + 1, 64);
    check_idle(0, 1);

    period = 1;
    clear_stats();
    send(0, 8'h81, 8'b10000001);
    send(0, 8'h7E, 8'b01111110);
    drain();
    chk("b2b_valid_cycles", vcnt[0], 16);
    chk("b2b_no_gap", last_c[0] - first_c[0] + 1, 16);
    check_idle(0, 1);

    // Abort a word after three bits with an asynchronous reset.
    clear_stats();
    send(0, 8'hC1, 8'b11000001);
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    q0.delete();
    #1;
    check_idle(0, 0);
    check_idle(1, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_idle(0, 1);
    clear_stats();
    send(0, 8'h55, 8'b01010101);
    drain();
    chk("post_reset_valid_cycles", vcnt[0], 8);
    check_idle(0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
